// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C write-only master.
// Holds the controller state encoding, address width, the R/W bit value used
// for writes, and the SDA levels that mean ACK / NACK during the ninth bit.
package i2c_pkg;

    localparam int   I2C_ADDR_W = 7;
    localparam logic I2C_WRITE  = 1'b0;
    localparam logic ACK        = 1'b0;
    localparam logic NACK       = 1'b1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_BIT,
        S_ACK,
        S_STOP
    } state_e;

endpackage

// File: rtl/i2c_clk_div.sv
// Quarter-period strobe generator for the I2C master.
// Ports:
//   clk   - clock
//   rst_n - synchronous active-low reset
//   clr   - holds the divider at zero (asserted while the master is idle)
//   tick  - one-cycle strobe every CLK_DIV cycles once released
// Because the counter sits at zero while idle, counting begins in the accept
// cycle itself, so the first tick lands CLK_DIV-1 cycles after accept.
module i2c_clk_div #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign tick = (cnt_q == CW'(CLK_DIV - 1));

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clr || tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/i2c_master_tx.sv
// Write-only I2C master: START, address byte {id,W}, nbytes payload bytes
// (byte 0 first, MSB first), ACK check after every byte, STOP.
// Ports:
//   clk, rst_n      - clock, synchronous active-low reset
//   valid / ready   - request handshake; ready is high only while idle
//   id, nbytes,data - target address, payload count (0 = probe), payload
//   scl, sda_oe     - registered line drives (sda_oe=1 pulls SDA low)
//   sda_i           - SDA line as seen by the master, sampled for ACK
//   done            - one-cycle pulse when the bus returns to idle
//   ack_err         - a NACK ended the most recent transaction
module i2c_master_tx
    import i2c_pkg::*;
#(
    parameter int CLK_DIV   = 4,
    parameter int MAX_BYTES = 4,
    parameter int BW        = $clog2(MAX_BYTES + 1)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   valid,
    input  logic [I2C_ADDR_W-1:0]  id,
    input  logic [BW-1:0]          nbytes,
    input  logic [8*MAX_BYTES-1:0] data,
    output logic                   ready,
    output logic                   scl,
    output logic                   sda_oe,
    input  logic                   sda_i,
    output logic                   done,
    output logic                   ack_err
);

    state_e                 state_q, state_d;
    logic [1:0]             qtr_q, qtr_d;
    logic [2:0]             bit_q, bit_d;
    logic [BW-1:0]          byte_q, byte_d;
    logic [BW-1:0]          nb_q, nb_d;
    logic [7:0]             sh_q, sh_d;
    logic [8*MAX_BYTES-1:0] data_q, data_d;
    logic                   scl_q, scl_d;
    logic                   sda_oe_q, sda_oe_d;
    logic                   done_q, done_d;
    logic                   ack_err_q, ack_err_d;
    logic                   tick;
    logic                   accept;
    logic [7:0]             next_byte;

    assign ready  = (state_q == S_IDLE);
    assign accept = valid && ready;

    i2c_clk_div #(.CLK_DIV(CLK_DIV)) u_div (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (ready && !valid),
        .tick  (tick)
    );

    // Line levels {scl, sda_oe} for a given state/quarter. Driven from the
    // next-state values so the registered outputs line up with the state.
    function automatic logic [1:0] lines(state_e s, logic [1:0] qtr, logic b);
        logic [1:0] l;
        l = 2'b10;
        case (s)
            S_START: l = {1'b1, qtr != 2'd0};
            S_BIT:   l = {qtr[1], ~b};
            S_ACK:   l = {qtr[1], 1'b0};
            S_STOP:  l = {qtr != 2'd0, qtr != 2'd2};
            default: l = 2'b10;
        endcase
        return l;
    endfunction

    always_comb begin
        next_byte = data_q[7:0];
        for (int k = 0; k < MAX_BYTES; k++) begin
            if (byte_q == BW'(k)) begin
                next_byte = data_q[8*k +: 8];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        qtr_d     = qtr_q;
        bit_d     = bit_q;
        byte_d    = byte_q;
        nb_d      = nb_q;
        sh_d      = sh_q;
        data_d    = data_q;
        ack_err_d = ack_err_q;
        done_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d   = S_START;
                    // The accept cycle already shows the START first-half
                    // levels, so it counts toward that quarter; with
                    // CLK_DIV=1 that quarter is already complete.
                    qtr_d     = tick ? 2'd1 : 2'd0;
                    bit_d     = '0;
                    byte_d    = '0;
                    sh_d      = {id, I2C_WRITE};
                    nb_d      = (nbytes > BW'(MAX_BYTES)) ? BW'(MAX_BYTES) : nbytes;
                    data_d    = data;
                    ack_err_d = 1'b0;
                end
            end
            S_START: begin
                if (tick) begin
                    qtr_d = qtr_q + 2'd1;
                    if (qtr_q == 2'd1) begin
                        state_d = S_BIT;
                        qtr_d   = 2'd0;
                    end
                end
            end
            S_BIT: begin
                if (tick) begin
                    qtr_d = qtr_q + 2'd1;
                    if (qtr_q == 2'd3) begin
                        sh_d  = {sh_q[6:0], 1'b0};
                        bit_d = bit_q + 3'd1;
                        if (bit_q == 3'd7) begin
                            state_d = S_ACK;
                        end
                    end
                end
            end
            S_ACK: begin
                if (tick) begin
                    qtr_d = qtr_q + 2'd1;
                    if (qtr_q == 2'd2 && sda_i != ACK) begin
                        ack_err_d = 1'b1;
                    end
                    if (qtr_q == 2'd3) begin
                        if (ack_err_q || byte_q == nb_q) begin
                            state_d = S_STOP;
                        end else begin
                            state_d = S_BIT;
                            sh_d    = next_byte;
                            byte_d  = byte_q + 1'b1;
                        end
                    end
                end
            end
            S_STOP: begin
                if (tick) begin
                    qtr_d = qtr_q + 2'd1;
                    if (qtr_q == 2'd2) begin
                        state_d = S_IDLE;
                        qtr_d   = 2'd0;
                        done_d  = 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                qtr_d   = 2'd0;
            end
        endcase

        {scl_d, sda_oe_d} = lines(state_d, qtr_d, sh_d[7]);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            qtr_q     <= '0;
            bit_q     <= '0;
            byte_q    <= '0;
            nb_q      <= '0;
            sh_q      <= '0;
            data_q    <= '0;
            scl_q     <= 1'b1;
            sda_oe_q  <= 1'b0;
            done_q    <= 1'b0;
            ack_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            qtr_q     <= qtr_d;
            bit_q     <= bit_d;
            byte_q    <= byte_d;
            nb_q      <= nb_d;
            sh_q      <= sh_d;
            data_q    <= data_d;
            scl_q     <= scl_d;
            sda_oe_q  <= sda_oe_d;
            done_q    <= done_d;
            ack_err_q <= ack_err_d;
        end
    end

    assign scl     = scl_q;
    assign sda_oe  = sda_oe_q;
    assign done    = done_q;
    assign ack_err = ack_err_q;

endmodule

// File: tb/tb_i2c_master_tx.sv
`timescale 1ns/1ps
module tb_i2c_master_tx;
    import i2c_pkg::*;

    localparam int MB = 4;
    localparam int BW = 3;

    typedef struct {
        int lat;
        bit err;
        int nbits;
        int nack;
    } txn_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n = 1'b0;
    logic          valid = 1'b0;
    logic          sel   = 1'b0;
    logic          sda_i = 1'b1;
    logic [6:0]    id    = '0;
    logic [BW-1:0] nbytes = '0;
    logic [31:0]   data  = '0;
    logic          v4, v1;
    logic          rdy4, scl4, oe4, done4, err4;
    logic          rdy1, scl1, oe1, done1, err1;
    logic          m_ready, m_scl, m_oe, m_done, m_err;

    assign v4 = valid && !sel;
    assign v1 = valid && sel;

    i2c_master_tx #(.CLK_DIV(4), .MAX_BYTES(MB)) dut4 (
        .clk(clk), .rst_n(rst_n), .valid(v4), .id(id), .nbytes(nbytes), .data(data),
        .ready(rdy4), .scl(scl4), .sda_oe(oe4), .sda_i(sda_i), .done(done4), .ack_err(err4));

    i2c_master_tx #(.CLK_DIV(1), .MAX_BYTES(MB)) dut1 (
        .clk(clk), .rst_n(rst_n), .valid(v1), .id(id), .nbytes(nbytes), .data(data),
        .ready(rdy1), .scl(scl1), .sda_oe(oe1), .sda_i(sda_i), .done(done1), .ack_err(err1));

    assign m_ready = sel ? rdy1 : rdy4;
    assign m_scl   = sel ? scl1 : scl4;
    assign m_oe    = sel ? oe1  : oe4;
    assign m_done  = sel ? done1 : done4;
    assign m_err   = sel ? err1 : err4;

    int   vecs = 0;
    int   errs = 0;
    int   cyc  = 0;
    txn_t txq[$];
    bit   bitq[$];
    txn_t cur;
    bit   active = 1'b0;
    int   acc = 0, rx = 0, r = 0, stop_cyc = -1, done_cnt = 0, last_done = -1;
    logic prev_scl = 1'b1, prev_oe = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int dsel();
        return sel ? 1 : 4;
    endfunction

    // Monitor, scoreboard and slave model; everything sampled mid-cycle.
    always @(negedge clk) begin
        if (!rst_n) begin
            bitq.delete();
            txq.delete();
            active   = 1'b0;
            r        = 0;
            sda_i    = 1'b1;
            prev_scl = 1'b1;
            prev_oe  = 1'b0;
        end else begin
            if (m_done) begin
                vecs++;
                if (!active) begin
                    errs++;
                    $display("FAIL done_spurious: done=1 at cycle %0d, required 0", cyc);
                end else begin
                    if (cyc - acc != cur.lat) begin
                        errs++;
                        $display("FAIL done_latency: got %0d required %0d", cyc - acc, cur.lat);
                    end
                    if (m_err !== cur.err) begin
                        errs++;
                        $display("FAIL ack_err_at_done: got %b required %b", m_err, cur.err);
                    end
                    if (rx != cur.nbits) begin
                        errs++;
                        $display("FAIL scl_edges: got %0d required %0d", rx, cur.nbits);
                    end
                    if (stop_cyc != cyc - dsel()) begin
                        errs++;
                        $display("FAIL stop_cond: got offset %0d required %0d", cyc - stop_cyc, dsel());
                    end
                    if (m_ready !== 1'b1) begin
                        errs++;
                        $display("FAIL ready_at_done: got %b required 1", m_ready);
                    end
                    done_cnt++;
                    last_done = cyc;
                    active    = 1'b0;
                end
            end
            if (valid && m_ready) begin
                if (txq.size() == 0) begin
                    vecs++;
                    errs++;
                    $display("FAIL unexpected_accept: accept at cycle %0d, required none", cyc);
                end else begin
                    cur      = txq.pop_front();
                    active   = 1'b1;
                    acc      = cyc;
                    rx       = 0;
                    r        = 0;
                    stop_cyc = -1;
                end
            end
            if (m_scl && !prev_scl) begin
                rx++;
                r++;
                vecs++;
                if (bitq.size() == 0) begin
                    errs++;
                    $display("FAIL extra_scl_edge: cycle %0d, required none", cyc);
                end else begin
                    bit e;
                    e = bitq.pop_front();
                    if (~m_oe !== e) begin
                        errs++;
                        $display("FAIL sda_bit %0d: got %b required %b", rx, ~m_oe, e);
                    end
                end
            end
            if (!m_scl && prev_scl) begin
                if (active && (r % 9) == 8)
                    sda_i = ((r / 9) == cur.nack) ? NACK : ACK;
                else
                    sda_i = 1'b1;
            end
            if (m_scl && prev_scl && m_oe != prev_oe) begin
                if (m_oe) begin
                    vecs++;
                    if (!active || cyc - acc != dsel()) begin
                        errs++;
                        $display("FAIL start_cond: got offset %0d required %0d", cyc - acc, dsel());
                    end
                end else begin
                    stop_cyc = cyc;
                end
            end
            prev_scl = m_scl;
            prev_oe  = m_oe;
        end
    end

    // Push the expected SDA bit stream and outcome, then request a transfer.
    // nack: byte slot the slave NACKs (0 = address), -1 for none.
    task automatic issue(input logic [6:0] a, input logic [BW-1:0] nb, input logic [31:0] d,
                         input int nack, input bit hold, output int acc_c);
        txn_t       t;
        int         nbc, n, w;
        bit         ok;
        logic [7:0] by;
        nbc     = (nb > MB) ? MB : int'(nb);
        t.err   = (nack >= 0 && nack <= nbc);
        n       = t.err ? nack : nbc;
        t.lat   = (5 + 36 * (n + 1)) * dsel();
        t.nbits = 9 * (n + 1) + 1;
        t.nack  = nack;
        for (int s = 0; s <= n; s++) begin
            by = (s == 0) ? {a, 1'b0} : d[8*(s-1) +: 8];
            for (int b = 7; b >= 0; b--) bitq.push_back(by[b]);
            bitq.push_back(1'b1);
        end
        bitq.push_back(1'b0);  // SCL rise of STOP, SDA still held low
        txq.push_back(t);
        @(posedge clk); #1;
        id = a; nbytes = nb; data = d; valid = 1'b1;
        ok = 1'b0;
        w  = 0;
        acc_c = -1;
        while (!ok && w < 4000) begin
            @(negedge clk);
            if (m_ready) begin ok = 1'b1; acc_c = cyc; end
            w++;
        end
        vecs++;
        if (!ok) begin
            errs++;
            $display("FAIL accept_timeout: ready=%b, required 1", m_ready);
            valid = 1'b0;
        end else begin
            @(posedge clk); #1;
            if (!hold) valid = 1'b0;
            id = ~a; data = ~d; nbytes = ~nb;
            @(negedge clk);
            vecs++;
            if (m_err !== 1'b0 || m_ready !== 1'b0) begin
                errs++;
                $display("FAIL after_accept: ack_err=%b ready=%b required 0 0", m_err, m_ready);
            end
        end
    endtask

    task automatic wait_done(input int budget);
        int start, w;
        start = done_cnt;
        w     = 0;
        while (done_cnt == start && w < budget) begin
            @(negedge clk);
            w++;
        end
        vecs++;
        if (done_cnt == start) begin
            errs++;
            $display("FAIL done_timeout: no done in %0d cycles", budget);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        vecs++;
        if ({scl4, oe4, rdy4, done4, err4} !== 5'b10100) begin
            errs++;
            $display("FAIL reset_d4: scl,oe,ready,done,err=%b required 10100", {scl4, oe4, rdy4, done4, err4});
        end
        vecs++;
        if ({scl1, oe1, rdy1, done1, err1} !== 5'b10100) begin
            errs++;
            $display("FAIL reset_d1: scl,oe,ready,done,err=%b required 10100", {scl1, oe1, rdy1, done1, err1});
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        vecs++;
        if ({m_scl, m_oe, m_ready, m_done} !== 4'b1010) begin
            errs++;
            $display("FAIL idle_after_reset: scl,oe,ready,done=%b required 1010", {m_scl, m_oe, m_ready, m_done});
        end
    endtask

    task automatic test_one_byte();
        int a;
        sel = 1'b0;
        issue(7'h50, 3'd1, 32'h0000_00A5, -1, 1'b0, a);
        // A request while busy must be ignored.
        repeat (50) @(posedge clk);
        #1 valid = 1'b1;
        repeat (5) @(posedge clk);
        #1 valid = 1'b0;
        wait_done(2000);
    endtask

    task automatic test_addr_only();
        int a;
        issue(7'h3C, 3'd0, 32'hDEAD_BEEF, -1, 1'b0, a);
        wait_done(2000);
    endtask

    task automatic test_nack_addr();
        int a, bad;
        issue(7'h2A, 3'd3, 32'h0011_2233, 0, 1'b0, a);
        wait_done(2000);
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (m_err !== 1'b1) bad++;
        end
        vecs++;
        if (bad != 0) begin
            errs++;
            $display("FAIL ack_err_hold: %0d idle cycles with ack_err=0, required 1", bad);
        end
    endtask

    task automatic test_nack_data();
        int a;
        issue(7'h11, 3'd3, 32'h00C3_5A96, 1, 1'b0, a);
        wait_done(2000);
    endtask

    task automatic test_mid_reset();
        int a, w, bad, dc;
        issue(7'h12, 3'd3, 32'h00F0_0F81, -1, 1'b0, a);
        w = 0;
        while (rx < 21 && w < 3000) begin
            @(negedge clk);
            w++;
        end
        vecs++;
        if (rx < 21) begin
            errs++;
            $display("FAIL reach_byte2: %0d scl edges, required 21", rx);
        end
        dc = done_cnt;
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        vecs++;
        if ({m_scl, m_oe, m_ready, m_done, m_err} !== 5'b10100) begin
            errs++;
            $display("FAIL abort_reset: scl,oe,ready,done,err=%b required 10100", {m_scl, m_oe, m_ready, m_done, m_err});
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        bad = 0;
        repeat (400) begin
            @(negedge clk);
            if (m_scl !== 1'b1 || m_oe !== 1'b0 || m_done !== 1'b0) bad++;
        end
        vecs++;
        if (bad != 0 || done_cnt != dc) begin
            errs++;
            $display("FAIL after_abort: %0d busy cycles, %0d done pulses, required 0 0", bad, done_cnt - dc);
        end
    endtask

    task automatic test_back_to_back();
        int a0, a1, a2;
        @(posedge clk); #1;
        sel = 1'b1;
        issue(7'h5A, 3'd2, 32'h0000_3CA5, -1, 1'b1, a0);
        issue(7'h07, 3'd7, 32'h8142_24FF, -1, 1'b1, a1);
        vecs++;
        if (a1 != last_done) begin
            errs++;
            $display("FAIL b2b_gap1: accept at %0d, required done cycle %0d", a1, last_done);
        end
        issue(7'h33, 3'd1, 32'h0000_00E7, 1, 1'b0, a2);
        vecs++;
        if (a2 != last_done) begin
            errs++;
            $display("FAIL b2b_gap2: accept at %0d, required done cycle %0d", a2, last_done);
        end
        wait_done(2000);
        @(negedge clk);
        vecs++;
        if (m_err !== 1'b1) begin
            errs++;
            $display("FAIL b2b_ack_err: got %b required 1", m_err);
        end
    endtask

    initial begin
        test_reset();
        test_one_byte();
        test_addr_only();
        test_nack_addr();
        test_nack_data();
        test_mid_reset();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
